// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared FSM states, CAN frame field constants and the CRC-15 step function
package can_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    RECV,
    DELIM,
    REPORT
  } state_t;

  localparam int STUFF_BITS       = 66;
  localparam int CRC_COVERED_BITS = 51;
  localparam int CRC_BITS         = 15;
  localparam int ID_BITS          = 11;
  localparam int DATA_BITS        = 32;
  localparam int RUN_LIMIT        = 5;

  localparam logic [5:0]  CTRL_VALUE = 6'b000100;
  localparam logic [14:0] CRC_POLY   = 15'h4599;

  // One bit of the CAN CRC-15 shift register, MSB-first.
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[14];
    crc15_step = {crc[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'h0000);
  endfunction

endpackage

// File: rtl/can_crc15_serial.sv
// rtl/can_crc15_serial.sv - serial CAN CRC-15 accumulator, used only when CAN_RX_CRC_CHECK_EN is defined
module can_crc15_serial
  import can_pkg::*;
(
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic        bit_i,
  output logic [14:0] crc_o
);

  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      crc_o <= '0;
    end else if (enable_i) begin
      crc_o <= crc15_step(crc_o, bit_i);
    end
  end

endmodule

// File: rtl/can_bit_destuffer.sv
// rtl/can_bit_destuffer.sv - CAN RX bit destuffer and frame field extractor
// Optional CRC-15 check is enabled by defining CAN_RX_CRC_CHECK_EN.
module can_bit_destuffer
  import can_pkg::*;
#(
  parameter int IDLE_BITS = 11
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        sample_pulse_i,
  input  logic        serial_i,
  output logic [10:0] msg_id_o,
  output logic [31:0] data_o,
  output logic [14:0] crc_o,
  output logic        valid_o,
  output logic        stuff_err_o,
  output logic        form_err_o,
  output logic        crc_err_o,
  output logic        bus_idle_o
);

  localparam int IW = $clog2(IDLE_BITS + 1);

  state_t        state;
  logic [IW-1:0] idle_cnt;
  logic [6:0]    bit_cnt;
  logic [2:0]    run_len;
  logic          last_bit;
  logic [64:0]   shreg;

  logic [6:0]    bit_cnt_nxt;
  logic [2:0]    run_nxt;
  logic [10:0]   rx_id;
  logic          rx_rtr;
  logic [5:0]    rx_ctrl;
  logic [31:0]   rx_data;
  logic [14:0]   rx_crc;

  // Everything after SOF is shifted in; the fields sit at fixed offsets once bit 66 arrives.
  assign rx_id   = shreg[64:54];
  assign rx_rtr  = shreg[53];
  assign rx_ctrl = shreg[52:47];
  assign rx_data = shreg[46:15];
  assign rx_crc  = shreg[14:0];

  assign bit_cnt_nxt = bit_cnt + 7'd1;
  assign run_nxt     = (serial_i == last_bit) ? run_len + 3'd1 : 3'd1;

`ifdef CAN_RX_CRC_CHECK_EN
  logic        crc_enable;
  logic [14:0] crc_calc;

  always_comb begin
    crc_enable = 1'b0;
    if (sample_pulse_i) begin
      if (state == IDLE && !serial_i) begin
        crc_enable = 1'b1;
      end
      if (state == RECV && run_len != 3'(RUN_LIMIT) && bit_cnt < 7'(CRC_COVERED_BITS)) begin
        crc_enable = 1'b1;
      end
    end
  end

  can_crc15_serial u_crc (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear_i (state == WAIT_IDLE),
    .enable_i(crc_enable),
    .bit_i   (serial_i),
    .crc_o   (crc_calc)
  );
`else
  assign crc_err_o = 1'b0;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state       <= WAIT_IDLE;
      idle_cnt    <= '0;
      bit_cnt     <= '0;
      run_len     <= '0;
      last_bit    <= 1'b0;
      shreg       <= '0;
      msg_id_o    <= '0;
      data_o      <= '0;
      crc_o       <= '0;
      valid_o     <= 1'b0;
      stuff_err_o <= 1'b0;
      form_err_o  <= 1'b0;
`ifdef CAN_RX_CRC_CHECK_EN
      crc_err_o   <= 1'b0;
`endif
      bus_idle_o  <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      stuff_err_o <= 1'b0;
      form_err_o  <= 1'b0;
`ifdef CAN_RX_CRC_CHECK_EN
      crc_err_o   <= 1'b0;
`endif
      if (state == REPORT) begin
        msg_id_o <= rx_id;
        data_o   <= rx_data;
        crc_o    <= rx_crc;
        valid_o  <= 1'b1;
        state    <= WAIT_IDLE;
      end else if (sample_pulse_i) begin
        case (state)
          WAIT_IDLE: begin
            if (!serial_i) begin
              idle_cnt <= '0;
            end else if (idle_cnt == IW'(IDLE_BITS - 1)) begin
              idle_cnt   <= '0;
              state      <= IDLE;
              bus_idle_o <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          IDLE: begin
            if (!serial_i) begin
              state      <= RECV;
              bus_idle_o <= 1'b0;
              bit_cnt    <= 7'd1;
              run_len    <= 3'd1;
              last_bit   <= 1'b0;
            end
          end
          RECV: begin
            if (run_len == 3'(RUN_LIMIT)) begin
              if (serial_i == last_bit) begin
                stuff_err_o <= 1'b1;
                state       <= WAIT_IDLE;
              end else begin
                run_len  <= 3'd1;
                last_bit <= serial_i;
                if (bit_cnt == 7'(STUFF_BITS)) begin
                  state <= DELIM;
                end
              end
            end else begin
              shreg    <= {shreg[63:0], serial_i};
              bit_cnt  <= bit_cnt_nxt;
              run_len  <= run_nxt;
              last_bit <= serial_i;
              // A run of five on the final CRC bit still owes a stuff bit before the delimiter.
              if (bit_cnt_nxt == 7'(STUFF_BITS) && run_nxt != 3'(RUN_LIMIT)) begin
                state <= DELIM;
              end
            end
          end
          DELIM: begin
            state <= WAIT_IDLE;
            if (!serial_i || rx_rtr || rx_ctrl != CTRL_VALUE) begin
              form_err_o <= 1'b1;
            end
`ifdef CAN_RX_CRC_CHECK_EN
            else if (crc_calc != rx_crc) begin
              crc_err_o <= 1'b1;
            end
`endif
            else begin
              state <= REPORT;
            end
          end
          default: state <= WAIT_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_bit_destuffer.sv
// tb/tb_can_bit_destuffer.sv - directed and randomized frame checks against a stuffing/CRC reference model
module tb_can_bit_destuffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sample_pulse = 1'b0;
  logic        serial = 1'b1;
  logic [10:0] msg_id;
  logic [31:0] data;
  logic [14:0] crc;
  logic        valid, stuff_err, form_err, crc_err, bus_idle;

  can_bit_destuffer #(.IDLE_BITS(11)) dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .sample_pulse_i(sample_pulse),
    .serial_i      (serial),
    .msg_id_o      (msg_id),
    .data_o        (data),
    .crc_o         (crc),
    .valid_o       (valid),
    .stuff_err_o   (stuff_err),
    .form_err_o    (form_err),
    .crc_err_o     (crc_err),
    .bus_idle_o    (bus_idle)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int valid_cnt = 0, stuff_cnt = 0, form_cnt = 0, crc_cnt = 0;

  always @(negedge clock) begin
    if (valid)     valid_cnt++;
    if (stuff_err) stuff_cnt++;
    if (form_err)  form_cnt++;
    if (crc_err)   crc_cnt++;
  end

  logic        tx_q[$];
  logic [14:0] model_crc;
  logic [3:0]  e1, e2;
  logic [3:0]  d_e1, d_e2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // CRC by polynomial long division of the 51 covered bits times x^15; bit stuffing by run counting.
  task automatic build_frame(input logic [10:0] id, input logic rtr, input logic [5:0] ctrl,
                             input logic [31:0] d, input logic [14:0] crc_xor);
    logic [50:0] covered;
    logic [65:0] div;
    logic [65:0] raw;
    int          run;
    logic        last;
    covered = {1'b0, id, rtr, ctrl, d};
    div = {covered, 15'b0};
    for (int i = 65; i >= 15; i--) begin
      if (div[i]) div[i -: 16] = div[i -: 16] ^ 16'hC599;
    end
    model_crc = div[14:0];
    raw = {covered, model_crc ^ crc_xor};
    tx_q.delete();
    run = 0;
    last = 1'b0;
    for (int i = 65; i >= 0; i--) begin
      tx_q.push_back(raw[i]);
      if (run > 0 && raw[i] == last) run++;
      else run = 1;
      last = raw[i];
      if (run == 5) begin
        tx_q.push_back(~last);
        last = ~last;
        run = 1;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clock);
    serial = b;
    sample_pulse = 1'b1;
    @(posedge clock);
    #1;
    e1 = {valid, stuff_err, form_err, crc_err};
    sample_pulse = 1'b0;
    @(posedge clock);
    #1;
    e2 = {valid, stuff_err, form_err, crc_err};
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [10:0] id, input logic rtr, input logic [5:0] ctrl,
                            input logic [31:0] d, input logic [14:0] crc_xor, input logic delim);
    build_frame(id, rtr, ctrl, d, crc_xor);
    foreach (tx_q[i]) send_bit(tx_q[i]);
    send_bit(delim);
    d_e1 = e1;
    d_e2 = e2;
    send_bit(1'b0);
    send_ones(11);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int v0, s0, f0, c0;
    logic [10:0] rid;
    logic [31:0] rdata;
    logic [14:0] last_crc;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_msg_id", msg_id, 0);
    check("reset_data", data, 0);
    check("reset_crc", crc, 0);
    check("reset_flags", {valid, stuff_err, form_err, crc_err, bus_idle}, 0);

    send_ones(10);
    check("idle_after_10", bus_idle, 0);
    send_ones(1);
    check("idle_after_11", bus_idle, 1);

    v0 = valid_cnt; s0 = stuff_cnt; f0 = form_cnt; c0 = crc_cnt;
    send_frame(11'h123, 1'b0, 6'b000100, 32'hDEADBEEF, 15'h0, 1'b1);
    check("first_delim_edge_flags", d_e1, 4'b0000);
    check("first_valid_latency", d_e2, 4'b1000);
    check("first_valid_count", valid_cnt - v0, 1);
    check("first_err_count", (stuff_cnt - s0) + (form_cnt - f0) + (crc_cnt - c0), 0);
    check("first_msg_id", msg_id, 11'h123);
    check("first_data", data, 32'hDEADBEEF);
    check("first_crc", crc, model_crc);
    check("idle_after_frame", bus_idle, 1);

    v0 = valid_cnt;
    send_frame(11'h123, 1'b0, 6'b000100, 32'h0, 15'h0, 1'b1);
    check("zero_valid_count", valid_cnt - v0, 1);
    check("zero_data", data, 32'h0);
    check("zero_crc", crc, model_crc);

    for (int k = 0; k < 6; k++) begin
      rid = 11'($urandom_range(0, 2047));
      rdata = $urandom;
      v0 = valid_cnt; s0 = stuff_cnt; f0 = form_cnt;
      send_frame(rid, 1'b0, 6'b000100, rdata, 15'h0, 1'b1);
      check("rand_valid_count", valid_cnt - v0, 1);
      check("rand_err_count", (stuff_cnt - s0) + (form_cnt - f0), 0);
      check("rand_msg_id", msg_id, rid);
      check("rand_data", data, rdata);
      check("rand_crc", crc, model_crc);
    end
    last_crc = crc;

    v0 = valid_cnt; s0 = stuff_cnt;
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    check("five_zeros_no_err", e1[2], 0);
    send_bit(1'b0);
    check("stuff_err_latency", e1, 4'b0100);
    check("stuff_err_one_cycle", e2[2], 0);
    send_ones(11);
    check("stuff_err_count", stuff_cnt - s0, 1);
    check("stuff_no_valid", valid_cnt - v0, 0);
    check("stuff_retain_data", data, rdata);

    v0 = valid_cnt;
    send_frame(11'h2A5, 1'b0, 6'b000100, 32'h12345678, 15'h0, 1'b1);
    check("reaccept_valid", valid_cnt - v0, 1);
    check("reaccept_id", msg_id, 11'h2A5);
    last_crc = crc;

    v0 = valid_cnt; f0 = form_cnt;
    send_frame(11'h055, 1'b0, 6'b000100, 32'hCAFEF00D, 15'h0, 1'b0);
    check("delim0_form_latency", d_e1, 4'b0010);
    check("delim0_form_count", form_cnt - f0, 1);
    check("delim0_no_valid", valid_cnt - v0, 0);
    check("delim0_retain_id", msg_id, 11'h2A5);
    check("delim0_retain_data", data, 32'h12345678);

    v0 = valid_cnt; f0 = form_cnt;
    send_frame(11'h055, 1'b0, 6'b000101, 32'hCAFEF00D, 15'h0, 1'b1);
    check("ctrl_form_latency", d_e1, 4'b0010);
    check("ctrl_form_count", form_cnt - f0, 1);
    check("ctrl_no_valid", valid_cnt - v0, 0);
    check("ctrl_retain_crc", crc, last_crc);

    v0 = valid_cnt; c0 = crc_cnt;
    send_frame(11'h321, 1'b0, 6'b000100, 32'hA5A5A5A5, 15'h0001, 1'b1);
`ifdef CAN_RX_CRC_CHECK_EN
    check("crcflip_latency", d_e1, 4'b0001);
    check("crcflip_err_count", crc_cnt - c0, 1);
    check("crcflip_no_valid", valid_cnt - v0, 0);
    check("crcflip_retain_data", data, 32'h12345678);
`else
    check("crcflip_valid", valid_cnt - v0, 1);
    check("crcflip_err_count", crc_cnt - c0, 0);
    check("crcflip_data", data, 32'hA5A5A5A5);
`endif

    do_reset();
    check("reset2_data", data, 0);
    check("reset2_idle", bus_idle, 0);
    v0 = valid_cnt; s0 = stuff_cnt; f0 = form_cnt; c0 = crc_cnt;
    send_ones(5);
    send_frame(11'h123, 1'b0, 6'b000100, 32'hDEADBEEF, 15'h0, 1'b1);
    check("short_idle_no_pulses",
          (valid_cnt - v0) + (stuff_cnt - s0) + (form_cnt - f0) + (crc_cnt - c0), 0);
    check("short_idle_data", data, 0);
    check("short_idle_then_idle", bus_idle, 1);

    build_frame(11'h3FF, 1'b0, 6'b000100, 32'h87654321, 15'h0);
    for (int i = 0; i < 20; i++) send_bit(tx_q[i]);
    v0 = valid_cnt; s0 = stuff_cnt; f0 = form_cnt; c0 = crc_cnt;
    do_reset();
    check("midreset_idle", bus_idle, 0);
    for (int i = 20; i < tx_q.size(); i++) send_bit(tx_q[i]);
    send_bit(1'b1);
    check("midreset_no_pulses",
          (valid_cnt - v0) + (stuff_cnt - s0) + (form_cnt - f0) + (crc_cnt - c0), 0);
    check("midreset_outputs", {msg_id, data, crc}, 0);

    send_ones(12);
    v0 = valid_cnt;
    send_frame(11'h7E1, 1'b0, 6'b000100, 32'hFFFFFFFF, 15'h0, 1'b1);
    check("final_valid", valid_cnt - v0, 1);
    check("final_data", data, 32'hFFFFFFFF);
    check("final_id", msg_id, 11'h7E1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/can_bit_destuffer.md
CAN_BIT_DESTUFFER -- requirements
Module: can_bit_destuffer

Interface
REQ-001 Parameter IDLE_BITS, default 11, SHALL set the number of consecutive recessive samples that define bus idle.
REQ-002 clock_i  input  1  SHALL be the system clock; all state changes on its rising edge.
REQ-003 reset_i  input  1  SHALL be a synchronous, active-high reset.
REQ-004 sample_pulse_i  input  1  SHALL be a one-cycle strobe marking each bit-time sample point.
REQ-005 serial_i  input  1  SHALL be the CAN RX line (1 = recessive), already synchronized.
REQ-006 msg_id_o  output  11  SHALL hold the received identifier.
REQ-007 data_o  output  32  SHALL hold the received data bytes, MSB first.
REQ-008 crc_o  output  15  SHALL hold the received CRC field.
REQ-009 valid_o  output  1  SHALL pulse for one cycle when a frame is accepted.
REQ-010 stuff_err_o, form_err_o, crc_err_o  output  1 each  SHALL each pulse for one cycle on the corresponding error.
REQ-011 bus_idle_o  output  1  SHALL be high while the FSM is in IDLE.

Function
REQ-012 Bit processing SHALL occur only on cycles where sample_pulse_i=1; all other cycles SHALL hold state.
REQ-013 The FSM SHALL have states WAIT_IDLE, IDLE, RECV, DELIM and REPORT.
REQ-014 WAIT_IDLE: count consecutive 1 samples, clear on any 0, go to IDLE when count reaches IDLE_BITS.
REQ-015 IDLE: a 0 sample SHALL be taken as SOF, go to RECV with bit count=1, run length=1, last bit=0.
REQ-016 RECV: with run length <5, store the sample as data bit, increment bit count, update run length and last bit.
REQ-017 RECV: with run length=5, the sample SHALL be a stuff bit and is discarded.
REQ-018 A stuff bit opposite to the last bit SHALL set run length=1 and last bit=sample.
REQ-019 A stuff bit equal to the last bit SHALL raise stuff_err_o and go to WAIT_IDLE.
REQ-020 The 66 stuffable bits SHALL be SOF, 11 ID, RTR, 6 control, 32 data and 15 CRC; the first 51 SHALL be the CRC-covered bits.
REQ-021 After bit 66, a pending stuff bit (run length=5) SHALL still be consumed in RECV; then go to DELIM.
REQ-022 DELIM: the sample SHALL be 1, else raise form_err_o and go to WAIT_IDLE; no stuffing applies.
REQ-023 A form error SHALL be raised at DELIM if RTR≠0 or control≠6'b000100.
REQ-024 REPORT SHALL last one clock: update msg_id_o/data_o/crc_o, pulse valid_o if error-free, then go to WAIT_IDLE.
REQ-025 valid_o SHALL assert exactly 1 clock after the delimiter sample edge.
REQ-026 ACK, EOF and IFS SHALL NOT be checked; they are absorbed by WAIT_IDLE.
REQ-027 Error pulses SHALL assert on the clock after the offending sample; at most one error per frame; valid_o never accompanies an error.
REQ-028 Data outputs SHALL hold their last accepted frame until the next valid_o.

Reset
REQ-029 On reset, the state SHALL be WAIT_IDLE with all counters and the shift register cleared.
REQ-030 On reset, all outputs SHALL be 0, including bus_idle_o.
REQ-031 Reset mid-frame SHALL abort the frame without any valid or error pulse.

Configuration
REQ-032 With CAN_RX_CRC_CHECK_EN defined, a serial CRC-15 over the 51 covered destuffed bits SHALL be compared with the received CRC at DELIM; a mismatch raises crc_err_o and suppresses valid_o.
REQ-033 Without CAN_RX_CRC_CHECK_EN, no CRC logic SHALL be instantiated and crc_err_o SHALL be tied to 0.

Structure
REQ-034 Package can_pkg SHALL hold the state enum, the field-length constants (66, 51, 15, 11, 32) and the control constant 6'b000100.
REQ-035 The CRC SHALL be a sub-module can_crc15_serial (polynomial 0x4599, clear, enable, bit in, 15-bit out), instantiated only under the macro.

Verification
REQ-036 After reset, feed 11 ones, then a stuffed frame with ID 0x123 and data 0xDEADBEEF (correct CRC) -> one valid_o; msg_id_o=0x123; data_o=0xDEADBEEF; no errors.
REQ-037 Frame with data 0x00000000 (maximal stuffing) -> valid_o; data_o=0; stuff bits removed; bit count=66 at DELIM.
REQ-038 Six consecutive 0s inside ID -> stuff_err_o 1 clock after the 6th sample; no valid_o; 11 ones then re-accept next frame.
REQ-039 Delimiter sampled 0, or control=6'b000101 -> form_err_o; outputs retain previous frame.
REQ-040 Only 5 ones after reset then SOF -> frame ignored; reset_i asserted mid-RECV -> no pulses, bus_idle_o=0, WAIT_IDLE.
REQ-041 With macro defined, flip one CRC bit -> crc_err_o pulse, no valid_o; without macro, same stimulus -> valid_o.
